// File: rtl/sound_pkg.sv
// Shared constants, frame type and slot bit selection for the I2S audio path.
package sound_pkg;

   localparam int ACC_INC_DEF = 245760;
   localparam int ACC_MOD_DEF = 742500;
   localparam int SLOT_BITS   = 32;
   localparam int DATA_BITS   = 16;

   typedef struct packed {
      logic [DATA_BITS-1:0] l;
      logic [DATA_BITS-1:0] r;
   } frame_t;

   // I2S puts the MSB one SCLK after the LRCK change, then 15 pad zeros
   function automatic logic slot_bit(input logic [DATA_BITS-1:0] word, input logic [4:0] pos);
      logic [4:0] idx;
      idx = 5'd16 - pos;
      if (pos == 5'd0 || pos > 5'd16) return 1'b0;
      return word[idx[3:0]];
   endfunction

endpackage

// File: rtl/sound_fifo.sv
// Small synchronous frame FIFO between the sound mixer and the I2S serialiser.
module sound_fifo
   import sound_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [SLOT_BITS-1:0] wr_data,
   output logic [SLOT_BITS-1:0] rd_data,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [SLOT_BITS-1:0] mem_q [DEPTH];
   logic [SLOT_BITS-1:0] mem_d [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // Guard internally so a misbehaving caller cannot corrupt the count
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sound_i2s.sv
// Stereo I2S output: fractional MCLK/SCLK/LRCK generation from clk_74a,
// frame buffering and MSB-first serialisation with one-bit I2S delay.
module sound_i2s
   import sound_pkg::*;
#(
   parameter int ACC_INC    = ACC_INC_DEF,
   parameter int ACC_MOD    = ACC_MOD_DEF,
   parameter int ACC_W      = 22,
   parameter int FIFO_DEPTH = 4,
   parameter int UNDER_HOLD = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] sample_l,
   input  logic [15:0] sample_r,
   input  logic        sample_valid,
   output logic        sample_ready,
   input  logic        mute,
   output logic        audio_mclk,
   output logic        audio_sclk,
   output logic        audio_lrck,
   output logic        audio_dac,
   output logic        underrun
);

   localparam int                 SUM_W = ACC_W + 1;
   localparam logic [SUM_W-1:0]   INC_V = SUM_W'(ACC_INC);
   localparam logic [SUM_W-1:0]   MOD_V = SUM_W'(ACC_MOD);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [SUM_W-1:0] acc_sum, acc_wrap;
   logic             toggle, mclk_rise, sclk_fall, load;
   logic             mclk_q, mclk_d;
   logic [1:0]       div_q, div_d;
   logic             sclk_q, sclk_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d, bit_nxt;
   logic             lrck_q, lrck_d;
   logic             dac_q, dac_d;
   logic             underrun_q, underrun_d;
   frame_t           frame_q, frame_d;
   logic [15:0]      slot_word;

   logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [SLOT_BITS-1:0] fifo_rd;

   assign fifo_push    = sample_valid & ~fifo_full;
   assign fifo_pop     = load & ~fifo_empty;
   assign sample_ready = ~fifo_full;

   sound_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .wr_data ({sample_l, sample_r}),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Fractional divider: MCLK toggles on every accumulator wrap
   always_comb begin
      acc_sum   = {1'b0, acc_q} + INC_V;
      acc_wrap  = acc_sum - MOD_V;
      toggle    = (acc_sum >= MOD_V);
      acc_d     = toggle ? acc_wrap[ACC_W-1:0] : acc_sum[ACC_W-1:0];
      mclk_d    = mclk_q ^ toggle;
      mclk_rise = toggle & ~mclk_q;
      div_d     = mclk_rise ? div_q + 2'd1 : div_q;
      sclk_d    = div_d[1];
      sclk_fall = mclk_rise && (div_q == 2'd3);
   end

   // Bit counter and serialiser; everything advances on the SCLK falling edge
   always_comb begin
      bit_nxt    = bit_cnt_q + 6'd1;
      load       = sclk_fall && (bit_nxt == 6'd0);
      bit_cnt_d  = bit_cnt_q;
      lrck_d     = lrck_q;
      dac_d      = dac_q;
      frame_d    = frame_q;
      underrun_d = load & fifo_empty;
      slot_word  = '0;
      if (!mute) slot_word = bit_nxt[5] ? frame_q.r : frame_q.l;
      if (sclk_fall) begin
         bit_cnt_d = bit_nxt;
         lrck_d    = bit_nxt[5];
         dac_d     = slot_bit(slot_word, bit_nxt[4:0]);
      end
      // No bypass: a frame pushed at the load edge waits for the next one
      if (load) begin
         if (!fifo_empty)          frame_d = frame_t'(fifo_rd);
         else if (UNDER_HOLD == 0) frame_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q      <= '0;
         mclk_q     <= 1'b0;
         div_q      <= 2'd0;
         sclk_q     <= 1'b0;
         bit_cnt_q  <= 6'd63;
         lrck_q     <= 1'b1;
         dac_q      <= 1'b0;
         frame_q    <= '0;
         underrun_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         mclk_q     <= mclk_d;
         div_q      <= div_d;
         sclk_q     <= sclk_d;
         bit_cnt_q  <= bit_cnt_d;
         lrck_q     <= lrck_d;
         dac_q      <= dac_d;
         frame_q    <= frame_d;
         underrun_q <= underrun_d;
      end
   end

   assign audio_mclk = mclk_q;
   assign audio_sclk = sclk_q;
   assign audio_lrck = lrck_q;
   assign audio_dac  = dac_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_sound_i2s.sv
// Bench for sound_i2s: closed-form clock model plus frame queue model, compared every cycle.
module tb_sound_i2s;

   localparam longint INC   = 245760;
   localparam longint MOD   = 742500;
   localparam int     DEPTH = 4;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic [15:0] sample_l = '0, sample_r = '0;
   logic        sample_valid = 1'b0, mute = 1'b0;
   logic        sample_ready, audio_mclk, audio_sclk, audio_lrck, audio_dac, underrun;
   logic        ready0, mclk0, sclk0, lrck0, dac0, und0;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   sound_i2s dut (
      .clk(clk), .reset_n(reset_n), .sample_l(sample_l), .sample_r(sample_r),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .mute(mute),
      .audio_mclk(audio_mclk), .audio_sclk(audio_sclk), .audio_lrck(audio_lrck),
      .audio_dac(audio_dac), .underrun(underrun)
   );

   sound_i2s #(.UNDER_HOLD(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .sample_l(sample_l), .sample_r(sample_r),
      .sample_valid(sample_valid), .sample_ready(ready0), .mute(mute),
      .audio_mclk(mclk0), .audio_sclk(sclk0), .audio_lrck(lrck0),
      .audio_dac(dac0), .underrun(und0)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint      n = 0, f_prev = 0;
   logic [31:0] mq[$];
   logic [31:0] fr_h = '0, fr_z = '0;
   logic        e_mclk = 0, e_sclk = 0, e_lrck = 1, e_dac = 0, e_dac0 = 0, e_und = 0, e_rdy = 1;
   int          load_cnt = 0, pushed = 0;
   bit          model_live = 0;

   function automatic logic exp_bit(input logic [31:0] fr, input int bc, input logic m);
      logic [15:0] w;
      int p;
      p = bc % 32;
      w = (bc >= 32) ? fr[15:0] : fr[31:16];
      if (m || p < 1 || p > 16) return 1'b0;
      return w[16-p];
   endfunction

   task automatic model_step();
      longint t, r, f;
      int     bc;
      bit     push_ok;
      n++;
      t = (n * INC) / MOD;          // MCLK toggles so far
      r = (t + 1) / 2;              // MCLK rises
      f = r / 4;                    // SCLK falls
      e_mclk  = t[0];
      e_sclk  = ((r % 4) >= 2);
      e_und   = 1'b0;
      push_ok = sample_valid && (mq.size() < DEPTH);
      if (f != f_prev) begin
         bc = int'((63 + f) % 64);
         e_lrck = (bc >= 32);
         if (bc == 0) begin
            load_cnt++;
            if (mq.size() > 0) begin
               fr_h = mq.pop_front();
               fr_z = fr_h;
            end else begin
               e_und = 1'b1;
               fr_z  = '0;
            end
         end
         e_dac  = exp_bit(fr_h, bc, mute);
         e_dac0 = exp_bit(fr_z, bc, mute);
      end
      f_prev = f;
      if (push_ok) begin
         mq.push_back({sample_l, sample_r});
         pushed++;
      end
      e_rdy = (mq.size() < DEPTH);
   endtask

   initial forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
         n = 0; f_prev = 0; mq.delete(); fr_h = '0; fr_z = '0;
         e_mclk = 0; e_sclk = 0; e_lrck = 1; e_dac = 0; e_dac0 = 0; e_und = 0; e_rdy = 1;
         model_live = 1;
      end else begin
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (model_live) begin
         chk("mclk", 64'(audio_mclk), 64'(e_mclk));
         chk("sclk", 64'(audio_sclk), 64'(e_sclk));
         chk("lrck", 64'(audio_lrck), 64'(e_lrck));
         chk("dac", 64'(audio_dac), 64'(e_dac));
         chk("underrun", 64'(underrun), 64'(e_und));
         chk("ready", 64'(sample_ready), 64'(e_rdy));
         chk("dac_zero_mode", 64'(dac0), 64'(e_dac0));
         chk("underrun_zero_mode", 64'(und0), 64'(e_und));
      end
   end

   // ---------------- frame / underrun monitor ----------------
   logic        m_ps = 0, m_pl = 1, m_pu = 0;
   int          m_cnt = -1, und_hi = 0;
   logic [63:0] mb = '0, mb0 = '0, ml = '0;
   logic [63:0] fq[$], fq0[$], lq[$];

   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         m_ps = 0; m_pl = 1; m_pu = 0; m_cnt = -1;
      end else begin
         if (underrun) und_hi++;
         if (underrun && m_pu) chk("underrun_width", 64'(underrun && m_pu), 64'(0));
         m_pu = underrun;
         if (m_ps && !audio_sclk) begin
            if (m_pl && !audio_lrck) m_cnt = 0;
            if (m_cnt >= 0) begin
               mb  = {mb[62:0], audio_dac};
               mb0 = {mb0[62:0], dac0};
               ml  = {ml[62:0], audio_lrck};
               m_cnt++;
               if (m_cnt == 64) begin
                  fq.push_back(mb); fq0.push_back(mb0); lq.push_back(ml);
                  m_cnt = -1;
               end
            end
         end
         m_ps = audio_sclk;
         m_pl = audio_lrck;
      end
   end

   // ---------------- stimulus driver ----------------
   int mode = 0, base = 0;

   initial forever begin
      @(posedge clk); #1;
      if (mode == 1) begin
         sample_valid = 1'b1;
         sample_l     = 16'(pushed - base);
         sample_r     = ~16'(pushed - base);
      end else if (mode == 2) begin
         sample_valid = ($urandom_range(0, 3) == 0);
         sample_l     = 16'($urandom);
         sample_r     = 16'($urandom);
         if ($urandom_range(0, 999) == 0) mute = ~mute;
      end
   end

   task automatic wait_load(input string tag);
      int start, cyc;
      start = load_cnt; cyc = 0;
      while (load_cnt == start && cyc < 4000) begin @(negedge clk); cyc++; end
      chk({"wait_load_", tag}, 64'(load_cnt != start), 64'(1));
   endtask

   task automatic wait_frames(input int k, input string tag);
      int cyc;
      cyc = 0;
      while (fq.size() < k && cyc < 2000 * k + 2000) begin @(negedge clk); cyc++; end
      chk({"wait_frames_", tag}, 64'(fq.size() >= k), 64'(1));
   endtask

   task automatic clear_frames();
      fq.delete(); fq0.delete(); lq.delete();
   endtask

   task automatic push_once(input logic [15:0] l, input logic [15:0] r);
      @(posedge clk); #1;
      sample_valid = 1'b1; sample_l = l; sample_r = r;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          cm, cs, cl, cu, cnt, cyc, l0, u0;
      logic        pm, ps, pl;
      logic [63:0] exp;
      logic [15:0] a;

      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_mclk", 64'(audio_mclk), 64'(0));
      chk("rst_sclk", 64'(audio_sclk), 64'(0));
      chk("rst_lrck", 64'(audio_lrck), 64'(1));
      chk("rst_dac", 64'(audio_dac), 64'(0));
      chk("rst_underrun", 64'(underrun), 64'(0));
      chk("rst_ready", 64'(sample_ready), 64'(1));

      // Clock ratio over one full accumulator period (12375 clk = 4096 toggles)
      cm = 0; cs = 0; cl = 0; cu = 0;
      pm = audio_mclk; ps = audio_sclk; pl = audio_lrck;
      for (int i = 0; i < 12375; i++) begin
         @(negedge clk);
         if (!pm && audio_mclk) cm++;
         if (!ps && audio_sclk) cs++;
         if (!pl && audio_lrck) cl++;
         if (underrun) cu++;
         pm = audio_mclk; ps = audio_sclk; pl = audio_lrck;
      end
      chk("ratio_mclk_rises", 64'(cm), 64'(2048));
      chk("ratio_sclk_periods", 64'(cs), 64'(512));
      chk("ratio_lrck_periods", 64'(cl), 64'(8));
      chk("ratio_underruns", 64'(cu), 64'(8));

      // Serial format
      wait_load("fmt");
      clear_frames();
      push_once(16'h8001, 16'h7FFE);
      wait_frames(2, "fmt");
      exp = {1'b0, 16'h8001, 15'd0, 1'b0, 16'h7FFE, 15'd0};
      if (fq.size() >= 2) begin
         chk("fmt_bits", fq[1], exp);
         chk("fmt_lrck", lq[1], {32'h0, 32'hFFFF_FFFF});
      end

      // Underrun hold / zero
      wait_load("under");
      clear_frames();
      push_once(16'hA5A5, 16'h5A5A);
      u0 = und_hi;
      wait_frames(3, "under");
      exp = {1'b0, 16'hA5A5, 15'd0, 1'b0, 16'h5A5A, 15'd0};
      if (fq.size() >= 3) begin
         chk("hold_pop", fq[1], exp);
         chk("hold_repeat", fq[2], exp);
         chk("zero_pop", fq0[1], exp);
         chk("zero_underrun_frame", fq0[2], 64'(0));
      end
      chk("underrun_pulses", 64'(und_hi - u0), 64'(1));

      // Backpressure with incrementing L
      wait_load("bp");
      clear_frames();
      base = pushed;
      mode = 1;
      cnt = 0; cyc = 0;
      do begin
         @(negedge clk);
         if (sample_valid && sample_ready) cnt++;
         cyc++;
      end while (sample_ready && cyc < 100);
      chk("bp_pushes_before_full", 64'(cnt), 64'(4));
      l0 = load_cnt; cnt = 0; cyc = 0;
      while (load_cnt < l0 + 2 && cyc < 5000) begin
         @(negedge clk);
         if (sample_ready) cnt++;
         cyc++;
      end
      repeat (4) begin @(negedge clk); if (sample_ready) cnt++; end
      chk("bp_ready_per_load", 64'(cnt), 64'(2));
      wait_frames(4, "bp");
      if (fq.size() >= 4)
         for (int i = 1; i < 4; i++) chk("bp_l_sequence", 64'(fq[i][62:47]), 64'(i - 1));

      // Mute mid-stream
      wait_load("mute");
      a = fq[fq.size()-1][62:47];
      @(posedge clk); #1 mute = 1'b1;
      clear_frames();
      wait_frames(1, "mute");
      @(posedge clk); #1 mute = 1'b0;
      wait_frames(2, "mute");
      if (fq.size() >= 2) begin
         chk("mute_zero_frame", fq[0], 64'(0));
         chk("mute_resume_l", 64'(fq[1][62:47]), 64'(a + 16'd2));
      end
      mode = 0;
      @(posedge clk); #1 sample_valid = 1'b0;

      // Reset during a left slot
      wait_load("rst");
      repeat (40) @(negedge clk);
      chk("pre_rst_left_slot", 64'(audio_lrck), 64'(0));
      @(posedge clk); #1 reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_mclk", 64'(audio_mclk), 64'(0));
      chk("mid_rst_sclk", 64'(audio_sclk), 64'(0));
      chk("mid_rst_lrck", 64'(audio_lrck), 64'(1));
      chk("mid_rst_dac", 64'(audio_dac), 64'(0));
      chk("mid_rst_underrun", 64'(underrun), 64'(0));
      chk("mid_rst_ready", 64'(sample_ready), 64'(1));
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      ps = audio_sclk; cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (ps && !audio_sclk) break;
         ps = audio_sclk;
      end while (cyc < 200);
      chk("post_rst_first_lrck", 64'(audio_lrck), 64'(0));
      chk("post_rst_first_underrun", 64'(underrun), 64'(1));

      // Randomized traffic with occasional mute flips
      l0 = load_cnt; cyc = 0;
      mode = 2;
      while (load_cnt < l0 + 6 && cyc < 12000) begin @(negedge clk); cyc++; end
      chk("random_loads", 64'(load_cnt >= l0 + 6), 64'(1));
      mode = 0;
      @(posedge clk); #1 sample_valid = 1'b0; mute = 1'b0;
      repeat (50) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
